// File: rtl/bus_decoder_pkg.sv
// Shared constants and types for the bus decoder / MMU.
// Port map of the fixed peripherals and the 0x78-0x7F control block.
package bus_decoder_pkg;

  typedef logic [1:0] win_idx_t;

  localparam logic [7:0] UART_BASE = 8'h70;
  localparam logic [7:0] KBD_BASE  = 8'h74;
  localparam logic [7:0] TTY_BASE  = 8'h76;
  localparam logic [7:0] CTRL_BASE = 8'h78;

  localparam logic [2:0] REG_PAGE0  = 3'd0;
  localparam logic [2:0] REG_PAGE1  = 3'd1;
  localparam logic [2:0] REG_PAGE2  = 3'd2;
  localparam logic [2:0] REG_PAGE3  = 3'd3;
  localparam logic [2:0] REG_WAIT   = 3'd4;
  localparam logic [2:0] REG_WPROT  = 3'd5;
  localparam logic [2:0] REG_ROMDIS = 3'd6;
  localparam logic [2:0] REG_IOBANK = 3'd7;

  localparam logic       RST_ROM_DISABLE = 1'b0;
  localparam logic [7:0] RST_IO_BANK     = 8'h00;
  localparam logic [3:0] RST_WP_MASK     = 4'h0;

endpackage

// File: rtl/bus_wait_gen.sv
// Z80 WAIT generator: holds wait_n low for N cycles from the first cycle of a
// request; control-port cycles bypass it entirely.
module bus_wait_gen #(
  parameter int WAIT_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req,
  input  logic [WAIT_W-1:0] n,
  input  logic              bypass,
  output logic              wait_n
);

  logic              req_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] n_eff;
  logic              start;

  assign n_eff  = bypass ? '0 : n;
  assign start  = req & ~req_q;
  assign wait_n = ~((start & (n_eff != '0)) | (cnt_q != '0));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      req_q <= req;
      // An aborted access drops any remaining wait cycles immediately.
      if (!req)
        cnt_q <= '0;
      else if (start && n_eff != '0)
        cnt_q <= n_eff - 1'b1;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/bus_decoder_mmu.sv
// Z80 address/IO decoder with 16K-window paging, banked IO and wait states.
// Optional macro WRITE_PROTECT_EN enables the per-window write-protect at 0x7D.
module bus_decoder_mmu
  import bus_decoder_pkg::*;
#(
  parameter int          PAGE_W  = 6,
  parameter int          NUM_IO  = 8,
  parameter logic [15:0] ROM_TOP = 16'h2000,
  parameter int          WAIT_W  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [15:0]          addr_i,
  input  logic [7:0]           data_i,
  input  logic                 wr_n,
  input  logic                 rd_n,
  input  logic                 mreq_n,
  input  logic                 ioreq_n,
  output logic [7:0]           data_o,
  output logic                 data_oe,
  output logic [PAGE_W+13:0]   phys_addr_o,
  output logic                 rom_cs,
  output logic                 ram_cs,
  output logic [NUM_IO-1:0]    io_cs,
  output logic                 uart_cs,
  output logic                 kbd_cs,
  output logic                 tty_cs,
  output logic                 ctrl_cs,
  output logic                 wait_n
);

  logic [PAGE_W-1:0] page_q [4];
  logic [WAIT_W-1:0] mem_wait_q, io_wait_q;
  logic              rom_disable_q;
  logic [7:0]        io_bank_q;

  logic [7:0] port;
  win_idx_t   win;
  logic       mem_act, io_act, is_fixed, is_ctrl, rom_sel, wp_hit, reg_we;
  logic [7:0] rd_val;

  assign port     = addr_i[7:0];
  assign win      = addr_i[15:14];
  assign mem_act  = ~mreq_n;
  assign io_act   = ~ioreq_n & mreq_n;
  assign is_fixed = (port[7:4] == UART_BASE[7:4]);
  assign is_ctrl  = (port[7:3] == CTRL_BASE[7:3]);

  assign phys_addr_o = {page_q[win], addr_i[13:0]};

  assign rom_sel = mem_act & (addr_i < ROM_TOP) & ~rom_disable_q;
  assign rom_cs  = rom_sel;
  assign ram_cs  = mem_act & ~rom_sel & ~wp_hit;

  assign uart_cs = io_act & (port[7:2] == UART_BASE[7:2]);
  assign kbd_cs  = io_act & (port[7:1] == KBD_BASE[7:1]);
  assign tty_cs  = io_act & (port[7:1] == TTY_BASE[7:1]);
  assign ctrl_cs = io_act & is_ctrl;

  // An out-of-range io_bank simply matches no bit.
  always_comb begin
    for (int i = 0; i < NUM_IO; i++)
      io_cs[i] = io_act & ~is_fixed & (io_bank_q == 8'(i));
  end

  assign reg_we = ~ioreq_n & ~wr_n & wait_n & is_ctrl;

`ifdef WRITE_PROTECT_EN
  logic [3:0] wp_mask_q;
  logic       wp_fault_q;

  assign wp_hit = mem_act & ~wr_n & ~rom_sel & wp_mask_q[win];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_mask_q  <= RST_WP_MASK;
      wp_fault_q <= 1'b0;
    end else if (reg_we && port[2:0] == REG_WPROT) begin
      wp_mask_q  <= data_i[3:0];
      wp_fault_q <= 1'b0;
    end else if (wp_hit) begin
      wp_fault_q <= 1'b1;
    end
  end
`else
  assign wp_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) page_q[i] <= PAGE_W'(i);
      mem_wait_q    <= '0;
      io_wait_q     <= '0;
      rom_disable_q <= RST_ROM_DISABLE;
      io_bank_q     <= RST_IO_BANK;
    end else if (reg_we) begin
      case (port[2:0])
        REG_PAGE0, REG_PAGE1, REG_PAGE2, REG_PAGE3:
          page_q[port[1:0]] <= PAGE_W'(data_i);
        REG_WAIT: begin
          mem_wait_q <= data_i[WAIT_W-1:0];
          io_wait_q  <= data_i[4 +: WAIT_W];
        end
        REG_ROMDIS: rom_disable_q <= data_i[0];
        REG_IOBANK: io_bank_q     <= data_i;
        default: ;
      endcase
    end
  end

  assign data_oe = ~ioreq_n & ~rd_n & is_ctrl;

  always_comb begin
    rd_val = '0;
    case (port[2:0])
      REG_PAGE0, REG_PAGE1, REG_PAGE2, REG_PAGE3:
        rd_val = 8'(page_q[port[1:0]]);
      REG_WAIT: begin
        rd_val[WAIT_W-1:0] = mem_wait_q;
        rd_val[4 +: WAIT_W] = io_wait_q;
      end
`ifdef WRITE_PROTECT_EN
      REG_WPROT: rd_val = {wp_fault_q, 3'b000, wp_mask_q};
`endif
      REG_ROMDIS: rd_val = {7'd0, rom_disable_q};
      REG_IOBANK: rd_val = io_bank_q;
      default: rd_val = '0;
    endcase
  end

  assign data_o = data_oe ? rd_val : 8'h00;

  bus_wait_gen #(.WAIT_W(WAIT_W)) u_wait (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     (~mreq_n | ~ioreq_n),
    .n       (mem_act ? mem_wait_q : io_wait_q),
    .bypass  (ctrl_cs),
    .wait_n  (wait_n)
  );

endmodule
